// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, and late
// multi-cycle results wait in a 2-entry in-order buffer, draining on idle writeback cycles.
//
// state  | meaning
// IDLE   | buffer empty, nothing pending
// PEND   | late results buffered, waiting for free write-port cycles
// STARVE | buffer starved too long; pipeline bubble requested
module wb_port_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        mc_valid,
  input  logic [2:0]  mc_reg,
  input  logic [15:0] mc_data,
  output logic        mc_ready,
  output logic        rf_we,
  output logic [2:0]  rf_wreg,
  output logic [15:0] rf_wdata,
  output logic        stall_req,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, PEND, STARVE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, cnt_nxt;
  logic        head, tail;
  logic        ent_v    [2];
  logic [2:0]  ent_reg  [2];
  logic [15:0] ent_data [2];
  logic [2:0]  stv, stv_nxt;
  logic        push, pop;

  assign mc_ready = (count < 2'd2);
  assign push     = mc_valid & mc_ready;
  assign pop      = ~wb_valid & (count != 2'd0);
  assign err      = rst & mc_valid & ~mc_ready;

  always_comb begin
    cnt_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    stv_nxt = stv;
    if (pop || count == 2'd0)
      stv_nxt = 3'd0;
    else if (wb_valid && stv != 3'd4)
      stv_nxt = stv + 3'd1;
  end

  // Write port is gated by rst so it reads as idle for the whole reset window.
  always_comb begin
    rf_we    = 1'b0;
    rf_wreg  = 3'd0;
    rf_wdata = 16'd0;
    if (rst) begin
      if (wb_valid) begin
        rf_we    = 1'b1;
        rf_wreg  = wb_reg;
        rf_wdata = wb_data;
      end else if (count != 2'd0 && ent_v[head]) begin
        rf_we    = 1'b1;
        rf_wreg  = ent_reg[head];
        rf_wdata = ent_data[head];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      stv   <= 3'd0;
      for (int i = 0; i < 2; i++) begin
        ent_v[i]    <= 1'b0;
        ent_reg[i]  <= 3'd0;
        ent_data[i] <= 16'd0;
      end
    end else begin
      count <= cnt_nxt;
      stv   <= stv_nxt;
      // A pipeline write to the same register makes the buffered value stale.
      if (wb_valid) begin
        for (int i = 0; i < 2; i++) begin
          if (ent_reg[i] == wb_reg && !(push && tail == 1'(i)))
            ent_v[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_v[head] <= 1'b0;
        head        <= ~head;
      end
      if (push) begin
        ent_v[tail]    <= 1'b1;
        ent_reg[tail]  <= mc_reg;
        ent_data[tail] <= mc_data;
        tail           <= ~tail;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = PEND;
      PEND: begin
        if (cnt_nxt == 2'd0)     state_nxt = IDLE;
        else if (stv_nxt == 3'd4) state_nxt = STARVE;
      end
      STARVE:  if (pop) state_nxt = (cnt_nxt == 2'd0) ? IDLE : PEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stall_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_req <= (state_nxt == STARVE);
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Bench for wb_port_arb: directed scenarios plus random traffic, checked each cycle
// against a queue-based model of the buffer, starvation count and stall flag.
module tb_wb_port_arb;

  logic        clk, rst;
  logic        wb_valid, mc_valid;
  logic [2:0]  wb_reg, mc_reg;
  logic [15:0] wb_data, mc_data;
  logic        mc_ready, rf_we, stall_req, err;
  logic [2:0]  rf_wreg;
  logic [15:0] rf_wdata;

  typedef struct packed {
    logic        v;
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  int   m_stv;
  logic m_starve;
  int   n_vec = 0;
  int   n_err = 0;

  wb_port_arb dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
    .mc_ready(mc_ready), .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge, then advance the model across the edge.
  task automatic step(input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                      input logic mv, input logic [2:0] mr, input logic [15:0] md);
    int          cnt;
    logic        rdy, psh, pp, ewe, silent;
    logic [2:0]  ereg;
    logic [15:0] edat;
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    mc_valid = mv; mc_reg = mr; mc_data = md;
    cnt = q.size();
    rdy = (cnt < 2);
    psh = mv && rdy;
    pp  = !wv && cnt > 0;
    ewe = 1'b0; ereg = 3'd0; edat = 16'd0; silent = 1'b0;
    if (wv) begin
      ewe = 1'b1; ereg = wr; edat = wd;
    end else if (cnt > 0) begin
      ewe = q[0].v;
      if (q[0].v) begin
        ereg = q[0].r; edat = q[0].d;
      end else
        silent = 1'b1;
    end
    @(negedge clk);
    n_vec++;
    chk("mc_ready", 16'(mc_ready), 16'(rdy));
    chk("err", 16'(err), 16'(mv && !rdy));
    chk("stall_req", 16'(stall_req), 16'(m_starve));
    chk("rf_we", 16'(rf_we), 16'(ewe));
    if (!silent) begin
      chk("rf_wreg", 16'(rf_wreg), 16'(ereg));
      chk("rf_wdata", rf_wdata, edat);
    end
    @(posedge clk);
    if (wv)
      foreach (q[i]) if (q[i].r == wr) q[i].v = 1'b0;
    if (pp) void'(q.pop_front());
    if (psh) q.push_back('{v: 1'b1, r: mr, d: md});
    if (pp || cnt == 0) m_stv = 0;
    else if (wv && m_stv < 4) m_stv++;
    if (m_starve) m_starve = !pp;
    else m_starve = (m_stv == 4) && (q.size() > 0);
    #1;
  endtask

  task automatic chk_reset_outputs();
    n_vec++;
    chk("rst_mc_ready", 16'(mc_ready), 16'd1);
    chk("rst_rf_we", 16'(rf_we), 16'd0);
    chk("rst_rf_wreg", 16'(rf_wreg), 16'd0);
    chk("rst_rf_wdata", rf_wdata, 16'd0);
    chk("rst_stall", 16'(stall_req), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    q.delete(); m_stv = 0; m_starve = 1'b0;
    rst = 1'b0;
    wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 16'h5555;
    mc_valid = 1'b1; mc_reg = 3'd2; mc_data = 16'h6666;
    #2;
    chk_reset_outputs();
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b1;

    // push with idle pipeline drains next cycle
    step(0, 0, 0, 1, 3'd3, 16'hBEEF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // pipeline priority over a buffered entry
    step(1, 3'd5, 16'h1234, 1, 3'd6, 16'hAAAA);
    step(1, 3'd5, 16'h1234, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // full buffer and overflow error
    step(1, 3'd0, 16'h0001, 1, 3'd1, 16'h1111);
    step(1, 3'd0, 16'h0002, 1, 3'd2, 16'h2222);
    step(1, 3'd0, 16'h0003, 1, 3'd3, 16'h3333);
    step(1, 3'd0, 16'h0004, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // supersede then silent pop
    step(1, 3'd4, 16'h4444, 1, 3'd2, 16'hCAFE);
    step(1, 3'd2, 16'h2020, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // starvation then drain
    step(1, 3'd7, 16'h7777, 1, 3'd1, 16'hD00D);
    for (int k = 0; k < 5; k++) step(1, 3'd0, 16'(k), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 9) < 9, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 16'($urandom));
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);

    // reset mid-flight with a full buffer in starvation
    step(1, 3'd0, 16'h0, 1, 3'd5, 16'h5A5A);
    step(1, 3'd0, 16'h0, 1, 3'd6, 16'h6B6B);
    for (int k = 0; k < 4; k++) step(1, 3'd0, 16'h0, 0, 0, 0);
    n_vec++;
    chk("pre_rst_stall", 16'(stall_req), 16'(m_starve));
    wb_valid = 1'b1; mc_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete(); m_stv = 0; m_starve = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd4, 16'hF00D);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
